// File: rtl/rijndael_stream_adapter.sv
// rijndael_stream_adapter
//   Valid/ready front end for the iterative rijndael_encrypt core. It accepts
//   one plaintext/key pair, launches the core with a single-cycle enable,
//   captures the ciphertext into an output buffer and hands it downstream
//   under backpressure. Only one block is ever in flight.
//
//   Build option: RIJNDAEL_STREAM_OBUF2_EN
//     defined   -> 2-entry output FIFO; a new block may be accepted while one
//                  ciphertext waits downstream.
//     undefined -> single output register; in_ready may follow out_ready
//                  combinationally so a pop and an accept can share a cycle.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         upstream handshake; in_plaintext/in_key payload
//   out_valid/out_ready       downstream handshake; out_ciphertext = buffer head
//   core_enable               one-cycle start pulse to the core
//   core_plaintext/core_key   block latched on accept, stable while busy
//   core_ready/core_ciphertext core status and result
//   busy                      high while a block is launching or in flight
//   block_count               ciphertext blocks popped downstream (wraps)
module rijndael_stream_adapter #(
  parameter int unsigned NB = 4,
  parameter int unsigned NK = 4,
  localparam int unsigned STATESIZE = 32 * NB,
  localparam int unsigned KEYSIZE   = 32 * NK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [STATESIZE-1:0] in_plaintext,
  input  logic [KEYSIZE-1:0]   in_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [STATESIZE-1:0] out_ciphertext,
  output logic                 core_enable,
  output logic [STATESIZE-1:0] core_plaintext,
  output logic [KEYSIZE-1:0]   core_key,
  input  logic                 core_ready,
  input  logic [STATESIZE-1:0] core_ciphertext,
  output logic                 busy,
  output logic [31:0]          block_count
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic [STATESIZE-1:0] pt_q, pt_d;
  logic [KEYSIZE-1:0]   key_q, key_d;
  logic [31:0]          block_count_q, block_count_d;

  logic room;
  logic capture;
  logic pop;

  assign capture = (state_q == S_WAIT) && core_ready;
  assign pop     = out_valid && out_ready;

  // ---------------------------------------------------------------- buffer
`ifdef RIJNDAEL_STREAM_OBUF2_EN
  logic [1:0]           occ_q, occ_d;
  logic [STATESIZE-1:0] e0_q, e0_d, e1_q, e1_d;

  // e0 is always the head; a pop shifts e1 forward before any push lands.
  always_comb begin
    occ_d = occ_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (pop) begin
      e0_d  = e1_q;
      occ_d = occ_q - 2'd1;
    end
    if (capture) begin
      if (occ_d == 2'd0) e0_d = core_ciphertext;
      else               e1_d = core_ciphertext;
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      occ_q <= occ_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign out_valid      = (occ_q != 2'd0);
  assign out_ciphertext = e0_q;
  assign room           = (occ_q != 2'd2);
`else
  logic                 obuf_vld_q, obuf_vld_d;
  logic [STATESIZE-1:0] obuf_q, obuf_d;

  always_comb begin
    obuf_vld_d = obuf_vld_q;
    obuf_d     = obuf_q;
    if (pop) obuf_vld_d = 1'b0;
    if (capture) begin
      obuf_vld_d = 1'b1;
      obuf_d     = core_ciphertext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obuf_vld_q <= 1'b0;
      obuf_q     <= '0;
    end else begin
      obuf_vld_q <= obuf_vld_d;
      obuf_q     <= obuf_d;
    end
  end

  assign out_valid      = obuf_vld_q;
  assign out_ciphertext = obuf_q;
  // Register frees up this cycle if the head is being popped.
  assign room           = !obuf_vld_q || out_ready;
`endif

  // ------------------------------------------------------------------- FSM
  // rst gates in_ready so it reads 0 for the whole reset window.
  assign in_ready = (state_q == S_IDLE) && room && !rst;

  always_comb begin
    state_d     = state_q;
    pt_d        = pt_q;
    key_d       = key_q;
    core_enable = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          pt_d    = in_plaintext;
          key_d   = in_key;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // Hold off while the core is still finishing (e.g. after reset).
        core_enable = core_ready;
        if (core_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign block_count_d = pop ? block_count_q + 32'd1 : block_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pt_q          <= '0;
      key_q         <= '0;
      block_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pt_q          <= pt_d;
      key_q         <= key_d;
      block_count_q <= block_count_d;
    end
  end

  assign core_plaintext = pt_q;
  assign core_key       = key_q;
  assign busy           = (state_q != S_IDLE);
  assign block_count    = block_count_q;

endmodule

// File: tb/tb_rijndael_stream_adapter.sv
// Directed bench for rijndael_stream_adapter. The core is modelled as a
// block that goes busy for 'lat' cycles after each enable and returns
// plaintext XOR key; expected ciphertexts below are precomputed constants.
module tb_rijndael_stream_adapter;

  localparam logic [127:0] PA = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] KA = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] CA = 128'h00102030_40506070_8090a0b0_c0d0e0f0;
  localparam logic [127:0] PB = 128'hffffffff_ffffffff_ffffffff_ffffffff;
  localparam logic [127:0] KB = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] CB = 128'hfedcba98_76543210_01234567_89abcdef;
  localparam logic [127:0] PC = 128'hdeadbeef_00000000_cafef00d_00000000;
  localparam logic [127:0] KC = 128'h0;
  localparam logic [127:0] CC = 128'hdeadbeef_00000000_cafef00d_00000000;
  localparam logic [127:0] PD = 128'h0;
  localparam logic [127:0] KD = 128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a;
  localparam logic [127:0] PE = 128'h00000000_00000000_00000000_00000001;
  localparam logic [127:0] KE = 128'h0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_plaintext = '0;
  logic [127:0] in_key = '0;
  logic         in_ready, out_valid, core_enable, busy, core_ready;
  logic [127:0] out_ciphertext, core_plaintext, core_key;
  logic [127:0] core_ciphertext;
  logic [31:0]  block_count;
  logic [31:0]  cnt0;

  int unsigned  checks = 0;
  int unsigned  failures = 0;
  int unsigned  lat = 10;
  logic         stall = 1'b0;
  int unsigned  core_cnt;
  int unsigned  n;

  always #5 clk = ~clk;

  rijndael_stream_adapter #(.NB(4), .NK(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_plaintext    (in_plaintext),
    .in_key          (in_key),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_ciphertext  (out_ciphertext),
    .core_enable     (core_enable),
    .core_plaintext  (core_plaintext),
    .core_key        (core_key),
    .core_ready      (core_ready),
    .core_ciphertext (core_ciphertext),
    .busy            (busy),
    .block_count     (block_count)
  );

  // Core model
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_cnt        <= 0;
      core_ciphertext <= '0;
    end else if (core_enable) begin
      core_cnt        <= lat;
      core_ciphertext <= core_plaintext ^ core_key;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
    end
  end
  assign core_ready = (core_cnt == 0) && !stall;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic [127:0] p, input logic [127:0] k, input string tag);
    in_valid = 1'b1; in_plaintext = p; in_key = k;
    #1;
    for (int i = 0; i < 64 && !in_ready; i++) step();
    chk({tag, "_accept"}, in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 64 && !out_valid; i++) step();
    chk({tag, "_valid"}, out_valid, 1);
  endtask

  task automatic expect_out(input logic [127:0] exp, input string tag);
    out_ready = 1'b1;
    #1;
    wait_valid(tag);
    chk({tag, "_ct"}, out_ciphertext, exp);
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 rst = 1'b1;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ct", out_ciphertext, 0);
    chk("rst_enable", core_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_pt", core_plaintext, 0);
    chk("rst_count", block_count, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // Single block, core busy for the enable cycle plus 10
    lat = 10; out_ready = 1'b1;
    in_valid = 1'b1; in_plaintext = PA; in_key = KA;
    step();
    in_valid = 1'b0;
    chk("t1_enable", core_enable, 1);
    chk("t1_core_pt", core_plaintext, PA);
    chk("t1_core_key", core_key, KA);
    chk("t1_in_ready_busy", in_ready, 0);
    step();
    chk("t1_enable_once", core_enable, 0);
    n = 2;
    while (!out_valid && n < 60) begin step(); n++; end
    chk("t1_latency", n, 13);
    chk("t1_ct", out_ciphertext, CA);
    step();
    out_ready = 1'b0;
    chk("t1_popped", out_valid, 0);
    chk("t1_count", block_count, 1);

    // Three blocks offered with downstream stalled
    lat = 3;
    offer(PA, KA, "t2a");
    in_valid = 1'b1; in_plaintext = PB; in_key = KB;
    repeat (14) step();
    chk("t2_full_in_ready", in_ready, 0);
    chk("t2_full_busy", busy, 0);
    chk("t2_head", out_ciphertext, CA);
`ifdef RIJNDAEL_STREAM_OBUF2_EN
    chk("t2_b_launched", core_plaintext, PB);
    in_plaintext = PC; in_key = KC;
    step();
    chk("t2_c_refused", in_ready, 0);
    expect_out(CA, "t2a");
    chk("t2_c_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("t2_c_launched", core_plaintext, PC);
`else
    chk("t2_b_held", core_plaintext, PA);
    out_ready = 1'b1;
    #1;
    chk("t2_pop_path_ready", in_ready, 1);
    expect_out(CA, "t2a");
    in_plaintext = PC; in_key = KC;
    chk("t2_b_launched", core_plaintext, PB);
    chk("t2_b_busy", busy, 1);
`endif
    expect_out(CB, "t2b");
    in_valid = 1'b0;
    chk("t2_c_latched", core_plaintext, PC);
    expect_out(CC, "t2c");
    chk("t2_count", block_count, 4);

    // Reset in WAIT, then core stalled after release
    lat = 10; out_ready = 1'b0;
    offer(PD, KD, "t3d");
    wait_valid("t3d");
`ifdef RIJNDAEL_STREAM_OBUF2_EN
    offer(PE, KE, "t3e");
`else
    in_valid = 1'b1; in_plaintext = PE; in_key = KE; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
`endif
    repeat (4) step();
    chk("t3_in_wait", busy, 1);
    rst = 1'b1; stall = 1'b1;
    step();
    chk("t3_rst_in_ready", in_ready, 0);
    chk("t3_rst_out_valid", out_valid, 0);
    rst = 1'b0; lat = 4;
    in_valid = 1'b1; in_plaintext = PC; in_key = KC;
    #1;
    chk("t3_post_out_valid", out_valid, 0);
    chk("t3_post_busy", busy, 0);
    chk("t3_post_count", block_count, 0);
    chk("t3_post_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("t4_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_enable", core_enable, 0);
      step();
    end
    stall = 1'b0;
    #1;
    chk("t4_enable_on_ready", core_enable, 1);
    step();
    chk("t4_enable_once", core_enable, 0);
    expect_out(CC, "t4");
    chk("t4_count", block_count, 1);

`ifdef RIJNDAEL_STREAM_OBUF2_EN
    // Push and pop in the same cycle at occupancy 1
    lat = 4;
    offer(PA, KA, "t5a");
    wait_valid("t5a");
    offer(PB, KB, "t5b");
    for (int i = 0; i < 64 && !(busy && !core_enable && core_ready); i++) step();
    chk("t5_capture_cycle", busy && core_ready, 1);
    cnt0 = block_count;
    out_ready = 1'b1;
    step();
    chk("t5_occ_kept", out_valid, 1);
    chk("t5_head", out_ciphertext, CB);
    chk("t5_count", block_count, cnt0 + 32'd1);
    step();
    out_ready = 1'b0;
    chk("t5_drained", out_valid, 0);
`endif

    // block_count wrap
    force dut.block_count_q = 32'hFFFF_FFFF;
    step();
    release dut.block_count_q;
    step();
    chk("t6_preload", block_count, 32'hFFFF_FFFF);
    lat = 2;
    offer(PB, KB, "t6");
    expect_out(CB, "t6");
    chk("t6_wrap", block_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
